// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder.
// State encoding and default operand width.
package serial_adder_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/serial_adder_fsm_full_adder.sv
// One-bit full adder cell used by the serial adder.
// Pure dataflow, no state.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder_fsm.sv
// Bit-serial adder, LSB first, start/busy/done handshake.
// Optional SERIAL_ADDER_OVF_EN adds a registered signed-overflow port Ovf.
module serial_adder_fsm
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             Ovf,
`endif
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             s_bit;
  logic             c_bit;
  logic [WIDTH-1:0] sum_nxt;

  full_adder u_fa (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Cin  (carry),
    .Sum  (s_bit),
    .Cout (c_bit)
  );

  // New bit enters at the MSB; after WIDTH steps the LSB lands at bit 0.
  assign sum_nxt = {s_bit, sum_sh};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      Sum    <= '0;
      Cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      Ovf    <= 1'b0;
`endif
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a_sh   <= A;
            b_sh   <= B;
            carry  <= Cin;
            sum_sh <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_nxt[WIDTH-1:1];
          carry  <= c_bit;
          if (cnt == LAST) begin
            Sum   <= sum_nxt;
            Cout  <= c_bit;
`ifdef SERIAL_ADDER_OVF_EN
            // carry still holds the carry into the MSB here
            Ovf   <= carry ^ c_bit;
`endif
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
